// File: rtl/adc_avg_bank.sv
// adc_avg_bank: thirteen-channel ADC sample averager feeding a UART packet stage.
//
// Accumulates 2^AVG_LOG2 samples per channel from a time-multiplexed sample
// stream, then publishes the completed averages on thirteen registered
// outputs. Publishing is suppressed while `hold` (packet stage `send`) is high,
// so a transmitted frame never mixes old and new values.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   sample_valid    sample strobe (one sample per cycle)
//   sample_ch[3:0]  channel index, 0..12 legal, 13..15 flagged via err_ch
//   sample_data     14-bit unsigned ADC sample
//   hold            freeze request; no publishing while high
//   clr_flags       synchronous clear of overrun/err_ch (set wins)
//   avg_01..avg_13  published averages for channels 0..12
//   upd             one-cycle pulse on the edge the averages update
//   overrun         sticky: an unpublished average was overwritten
//   err_ch          sticky: a sample with an illegal channel was received
//
// Build option: define AVG_ROUND_EN for round-half-up averages; otherwise the
// result is truncated.

module adc_avg_bank #(
  parameter int unsigned AVG_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [3:0]  sample_ch,
  input  logic [13:0] sample_data,
  input  logic        hold,
  input  logic        clr_flags,
  output logic [13:0] avg_01,
  output logic [13:0] avg_02,
  output logic [13:0] avg_03,
  output logic [13:0] avg_04,
  output logic [13:0] avg_05,
  output logic [13:0] avg_06,
  output logic [13:0] avg_07,
  output logic [13:0] avg_08,
  output logic [13:0] avg_09,
  output logic [13:0] avg_10,
  output logic [13:0] avg_11,
  output logic [13:0] avg_12,
  output logic [13:0] avg_13,
  output logic        upd,
  output logic        overrun,
  output logic        err_ch
);

  localparam int unsigned NCH = 13;
  localparam int unsigned AW  = 14 + AVG_LOG2;
  // One spare bit so the rounding constant can never wrap the sum.
  localparam int unsigned SW  = 15 + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CMAX = '1;
`ifdef AVG_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (AVG_LOG2 - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  logic [AW-1:0]       acc [NCH];
  logic [AVG_LOG2-1:0] cnt [NCH];
  logic [13:0]         pnd [NCH];
  logic [13:0]         avg [NCH];
  logic [NCH-1:0]      pf;

  logic           legal;
  logic           illegal;
  logic [3:0]     sel;
  logic           last;
  logic [SW-1:0]  sum;
  logic [13:0]    result;
  logic           publish;
  logic           ov_set;
  logic [NCH-1:0] pf_next;

  // A single shared adder serves whichever channel is being sampled.
  always_comb begin
    legal   = sample_valid && (sample_ch <= 4'd12);
    illegal = sample_valid && (sample_ch > 4'd12);
    sel     = legal ? sample_ch : '0;
    last    = (cnt[sel] == CMAX);
    sum     = SW'(acc[sel]) + SW'(sample_data) + RND;
    result  = sum[AVG_LOG2 +: 14];
    publish = !hold && (|pf);
    // A pending channel publishes whenever publish is true, so a completion
    // only overwrites unpublished data when no publish happens on this edge.
    ov_set  = legal && last && pf[sel] && !publish;
    pf_next = publish ? '0 : pf;
    if (legal && last) pf_next[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        pnd[i] <= '0;
        avg[i] <= '0;
      end
      pf      <= '0;
      upd     <= 1'b0;
      overrun <= 1'b0;
      err_ch  <= 1'b0;
    end else begin
      upd <= publish;
      // Publish reads the pre-edge pnd, so a same-edge completion is not lost.
      for (int unsigned i = 0; i < NCH; i++) begin
        if (publish && pf[i]) avg[i] <= pnd[i];
      end
      pf <= pf_next;
      if (legal) begin
        if (last) begin
          pnd[sel] <= result;
          acc[sel] <= '0;
          cnt[sel] <= '0;
        end else begin
          acc[sel] <= acc[sel] + AW'(sample_data);
          cnt[sel] <= cnt[sel] + 1'b1;
        end
      end
      overrun <= ov_set  | (overrun & ~clr_flags);
      err_ch  <= illegal | (err_ch  & ~clr_flags);
    end
  end

  assign avg_01 = avg[0];
  assign avg_02 = avg[1];
  assign avg_03 = avg[2];
  assign avg_04 = avg[3];
  assign avg_05 = avg[4];
  assign avg_06 = avg[5];
  assign avg_07 = avg[6];
  assign avg_08 = avg[7];
  assign avg_09 = avg[8];
  assign avg_10 = avg[9];
  assign avg_11 = avg[10];
  assign avg_12 = avg[11];
  assign avg_13 = avg[12];

endmodule

// File: tb/tb_adc_avg_bank.sv
// tb_adc_avg_bank: scoreboard bench for adc_avg_bank with AVG_LOG2 = 2.
// The reference model keeps raw sample lists per channel and averages them
// arithmetically; each modelled publish pushes the expected output vector,
// which a negedge monitor pops whenever the DUT pulses upd.

module tb_adc_avg_bank;

  localparam int unsigned L = 2;
  localparam int N = 1 << L;
`ifdef AVG_ROUND_EN
  localparam int RND = N / 2;
`else
  localparam int RND = 0;
`endif

  typedef logic [12:0][13:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [3:0]  sample_ch = '0;
  logic [13:0] sample_data = '0;
  logic        hold = 1'b0;
  logic        clr_flags = 1'b0;
  logic [13:0] avg_01, avg_02, avg_03, avg_04, avg_05, avg_06, avg_07;
  logic [13:0] avg_08, avg_09, avg_10, avg_11, avg_12, avg_13;
  logic        upd, overrun, err_ch;

  adc_avg_bank #(.AVG_LOG2(L)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .hold(hold), .clr_flags(clr_flags),
    .avg_01(avg_01), .avg_02(avg_02), .avg_03(avg_03), .avg_04(avg_04),
    .avg_05(avg_05), .avg_06(avg_06), .avg_07(avg_07), .avg_08(avg_08),
    .avg_09(avg_09), .avg_10(avg_10), .avg_11(avg_11), .avg_12(avg_12),
    .avg_13(avg_13), .upd(upd), .overrun(overrun), .err_ch(err_ch)
  );

  vec_t dout;
  assign dout = {avg_13, avg_12, avg_11, avg_10, avg_09, avg_08, avg_07,
                 avg_06, avg_05, avg_04, avg_03, avg_02, avg_01};

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state
  int   sq [13][$];
  int   m_pnd [13];
  bit   [12:0] m_pf;
  vec_t m_pub;
  bit   m_ov, m_err;
  vec_t exp_q [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 13; c++) begin
      sq[c].delete();
      m_pnd[c] = 0;
    end
    m_pf = '0; m_pub = '0; m_ov = 0; m_err = 0;
    exp_q.delete();
  endtask

  // Applies the effect of one clock edge given the currently driven inputs.
  task automatic model_edge();
    bit pub, ovs, errs;
    bit [12:0] pfb;
    int ch, s;
    if (rst) return;
    pfb = m_pf;
    pub = !hold && (m_pf != 0);
    ovs = 0; errs = 0;
    if (pub) begin
      for (int c = 0; c < 13; c++) if (m_pf[c]) m_pub[c] = 14'(m_pnd[c]);
      m_pf = '0;
      exp_q.push_back(m_pub);
    end
    if (sample_valid) begin
      ch = int'(sample_ch);
      if (ch > 12) errs = 1;
      else begin
        sq[ch].push_back(int'(sample_data));
        if (sq[ch].size() == N) begin
          s = 0;
          foreach (sq[ch][k]) s += sq[ch][k];
          sq[ch].delete();
          if (pfb[ch] && !pub) ovs = 1;
          m_pnd[ch] = (s + RND) / N;
          m_pf[ch] = 1;
        end
      end
    end
    m_ov  = ovs  || (m_ov  && !clr_flags);
    m_err = errs || (m_err && !clr_flags);
  endtask

  task automatic drive(input bit v, input int ch, input int d, input bit h, input bit clr);
    @(posedge clk);
    model_edge();
    #1;
    sample_valid = v;
    sample_ch    = 4'(ch);
    sample_data  = 14'(d);
    hold         = h;
    clr_flags    = clr;
  endtask

  task automatic smp(input int ch, input int d, input bit h);
    drive(1, ch, d, h, 0);
  endtask

  task automatic idle(input bit h, input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, h, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1; sample_valid = 0; hold = 0; clr_flags = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // Monitor: compares outputs at every negedge.
  initial begin : monitor
    vec_t shown, e;
    shown = '0;
    forever begin
      @(negedge clk);
      if (rst) shown = '0;
      if (upd) begin
        if (exp_q.size() == 0) chk("upd_unexpected", 256'(upd), 256'(0));
        else begin
          e = exp_q.pop_front();
          chk("avg_publish", 256'(dout), 256'(e));
          shown = e;
        end
      end else begin
        chk("upd_missing", 256'(exp_q.size()), 256'(0));
        chk("avg_held", 256'(dout), 256'(shown));
      end
      chk("overrun", 256'(overrun), 256'(m_ov));
      chk("err_ch", 256'(err_ch), 256'(m_err));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit h;
    model_reset();
    #12 rst = 0;

    // ch0 average
    smp(0, 100, 0); smp(0, 101, 0); smp(0, 102, 0); smp(0, 103, 0);
    idle(0, 3);
    chk("ch0_avg", 256'(avg_01), 256'(RND != 0 ? 102 : 101));

    // ch3 completes under hold, published on release
    for (int i = 0; i < N; i++) smp(3, 500, 1);
    idle(1, 10);
    chk("ch3_held", 256'(avg_04), 256'(0));
    idle(0, 3);
    chk("ch3_release", 256'(avg_04), 256'(500));

    // two ch5 completions under hold -> overrun
    for (int i = 0; i < N; i++) smp(5, 300, 1);
    for (int i = 0; i < N; i++) smp(5, 400, 1);
    idle(1, 2);
    chk("ch5_overrun", 256'(overrun), 256'(1));
    idle(0, 3);
    chk("ch5_latest", 256'(avg_06), 256'(400));
    drive(0, 0, 0, 0, 1);
    idle(0, 2);
    chk("overrun_clr", 256'(overrun), 256'(0));

    // illegal channel and sticky clear priority
    drive(1, 14, 999, 0, 0);
    idle(0, 2);
    chk("err_set", 256'(err_ch), 256'(1));
    drive(0, 0, 0, 0, 1);
    idle(0, 2);
    chk("err_clr", 256'(err_ch), 256'(0));
    drive(1, 15, 999, 0, 1);
    idle(0, 2);
    chk("err_set_wins", 256'(err_ch), 256'(1));
    drive(0, 0, 0, 0, 1);

    // reset discards partial sums
    smp(7, 1000, 0); smp(7, 1000, 0);
    do_reset();
    for (int i = 0; i < N; i++) smp(7, 200, 0);
    idle(0, 3);
    chk("ch7_after_reset", 256'(avg_08), 256'(200));

    // full-scale and simultaneous completion + publish on ch12
    for (int i = 0; i < N; i++) smp(12, 16383, 0);
    idle(0, 3);
    chk("ch12_fullscale", 256'(avg_13), 256'(16383));
    for (int i = 0; i < N; i++) smp(12, 8000, 1);
    for (int i = 0; i < N - 1; i++) smp(12, 4000, 1);
    smp(12, 4000, 0);
    idle(0, 1);
    chk("ch12_old_first", 256'(avg_13), 256'(8000));
    idle(0, 1);
    chk("ch12_new_next", 256'(avg_13), 256'(4000));
    chk("ch12_no_overrun", 256'(overrun), 256'(0));

    // randomized traffic
    h = 0;
    for (int i = 0; i < 1500; i++) begin
      int ch;
      if ($urandom_range(0, 7) == 0) h = !h;
      ch = ($urandom_range(0, 19) == 0) ? int'($urandom_range(13, 15)) : int'($urandom_range(0, 12));
      drive($urandom_range(0, 3) != 0, ch,
            (i % 97 == 0) ? 16383 : int'($urandom_range(0, 16383)),
            h, $urandom_range(0, 15) == 0);
    end

    idle(0, 4);
    chk("queue_drained", 256'(exp_q.size()), 256'(0));
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/adc_avg_bank.md
# adc_avg_bank

Thirteen-channel sample averager that directly feeds the `in_01`..`in_13` inputs of the external UART packet stage. It accepts a time-multiplexed stream of 14-bit ADC samples tagged with a channel index and accumulates 2^AVG_LOG2 samples per channel. Completed averages are presented on thirteen stable 14-bit outputs. Outputs are frozen while the packet stage's `send` is high, so a frame never mixes old and new values.

## Interface
- `AVG_LOG2`, default 4, log2 of samples per average; legal range 1..8.
- `clk`  input  1  system clock; all logic rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `sample_valid`  input  1  sample strobe; one sample per cycle when high.
- `sample_ch`  input  4  channel index; 0..12 valid, 13..15 illegal.
- `sample_data`  input  14  unsigned ADC sample.
- `hold`  input  1  freeze request; tied to the packet stage's `send`.
- `clr_flags`  input  1  synchronous clear of the sticky flags.
- `avg_01` .. `avg_13`  output  14 each  published averages for channels 0..12.
- `upd`  output  1  one-cycle pulse on the edge the `avg_xx` outputs update.
- `overrun`  output  1  sticky: an unpublished average was overwritten.
- `err_ch`  output  1  sticky: a sample with `sample_ch` ≥ 13 was received.

## Operation
- Per channel: accumulator `acc` (14+AVG_LOG2 bits), counter `cnt` (AVG_LOG2 bits), pending register `pnd` (14 bits) and flag `pf`.
- Accept (edge with `sample_valid`=1 and `sample_ch`≤12):
  - If `cnt` < 2^AVG_LOG2−1: `acc` += `sample_data`; `cnt`++.
  - If `cnt` = 2^AVG_LOG2−1 (completion): `pnd` ← (`acc`+`sample_data`) >> AVG_LOG2; `acc` ← 0; `cnt` ← 0; `pf` ← 1.
  - The accumulator never overflows; no saturation logic is required.
- Illegal channel: the sample is dropped, no channel state changes, and `err_ch` ← 1.
- Publish (edge with `hold`=0 and any `pf` set):
  - Each channel with `pf`=1 copies `pnd` to its `avg_xx` and clears `pf`.
  - All pending channels publish on the same edge; channels with `pf`=0 keep their value.
  - `upd` is 1 for exactly that cycle.
- While `hold`=1: no publishing; `avg_xx` and `upd`=0 are held.
- Overrun: a completion on a channel whose `pf` is already 1, while that channel is not publishing on the same edge, overwrites `pnd` and sets `overrun` ← 1.
- Completion and publish on the same edge, same channel:
  - The publish takes the pre-edge `pnd`.
  - The new result loads `pnd` and `pf` stays 1.
  - No overrun is flagged.
- Sticky flags: `clr_flags`=1 clears both. If a set event and a clear occur on the same edge, the set wins.
- Reset: all `acc`, `cnt`, `pnd`, `pf`, `avg_xx` = 0; `upd` = 0; `overrun` = 0; `err_ch` = 0. Reset asserted mid-accumulation discards partial sums.

## Timing
- Completing sample sampled at edge k: `pnd`/`pf` are valid after edge k.
- With `hold`=0, `avg_xx` and `upd` change at edge k+1, i.e. 2 edges from sample strobe to output.
- `hold` rising at edge j blocks publishing from edge j onward.
- `hold` falling, sampled low at edge m: pending data publishes at edge m.
- Back-to-back `sample_valid` on any mix of channels is sustained at 1 sample/cycle with no backpressure.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Configuration
- `AVG_ROUND_EN` defined:
  - Result = (`acc`+`sample_data`+2^(AVG_LOG2−1)) >> AVG_LOG2, i.e. round half up.
  - Maximum result stays 16383, so no clamp is needed.
- `AVG_ROUND_EN` undefined: result is truncated (plain shift).

## Test plan
- AVG_LOG2=2, `hold`=0; ch0 samples 100, 101, 102, 103 -> `avg_01` = 101 (truncating) or 102 (`AVG_ROUND_EN`), with `upd` pulsing 2 edges after the 4th sample; all other outputs stay 0.
- Complete ch3 average 500 with `hold`=1, then hold `hold` high for 10 cycles -> `avg_04` stays 0 and `upd`=0 throughout; `avg_04` = 500 and `upd`=1 on the first edge with `hold` sampled low.
- `hold`=1, two consecutive ch5 completions (averages 300, then 400) -> `overrun`=1; after release `avg_06` = 400.
- Sample with `sample_ch`=14, data 999 -> no output or accumulator change, `err_ch`=1; pulse `clr_flags` -> `err_ch`=0; then `clr_flags` coinciding with another illegal sample -> `err_ch` stays 1.
- Two ch7 samples of 1000, assert `rst`, then four samples of 200 -> `avg_08` = 200 (no residue from the earlier samples).
- Four ch12 samples of 16383 -> `avg_13` = 16383 in both configurations; simultaneous ch12 completion and publish of a prior pending value -> old value published, new value published on the next edge, `overrun`=0.
